// File: rtl/shift_taps_param.sv
// Tapped shift register with equally spaced taps, fill tracking, synchronous clear and
// a recirculate (rotate) mode for line-buffer / windowing datapaths.
module shift_taps_param #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned TAP_SPACING = 16,
  parameter int unsigned NUM_TAPS    = 4,
  localparam int unsigned DEPTH      = TAP_SPACING * NUM_TAPS,
  localparam int unsigned CW         = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      shift,
  input  logic                      recirc,
  input  logic                      clear,
  input  logic [WIDTH-1:0]          sr_in,
  output logic [NUM_TAPS*WIDTH-1:0] taps_out,
  output logic [WIDTH-1:0]          sr_out,
  output logic [NUM_TAPS-1:0]       taps_valid,
  output logic [CW-1:0]             fill_count,
  output logic                      full
);

  logic [WIDTH-1:0] sr_q [DEPTH];
  logic [WIDTH-1:0] sr_d [DEPTH];
  logic [CW-1:0]    fill_q, fill_d;

  always_comb begin
    sr_d   = sr_q;
    fill_d = fill_q;
    if (clear) begin
      for (int n = 0; n < DEPTH; n++) begin
        sr_d[n] = '0;
      end
      fill_d = '0;
    end else if (shift) begin
      for (int n = 1; n < DEPTH; n++) begin
        sr_d[n] = sr_q[n-1];
      end
      // Rotation keeps the fill count: nothing enters or leaves the line.
      sr_d[0] = recirc ? sr_q[DEPTH-1] : sr_in;
      if (!recirc && (fill_q != CW'(DEPTH))) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < DEPTH; n++) begin
        sr_q[n] <= '0;
      end
      fill_q <= '0;
    end else begin
      for (int n = 0; n < DEPTH; n++) begin
        sr_q[n] <= sr_d[n];
      end
      fill_q <= fill_d;
    end
  end

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    assign taps_out[k*WIDTH +: WIDTH] = sr_q[(k+1)*TAP_SPACING-1];
    assign taps_valid[k]              = (fill_q >= CW'((k+1) * TAP_SPACING));
  end

  assign sr_out     = sr_q[DEPTH-1];
  assign fill_count = fill_q;
  assign full       = (fill_q == CW'(DEPTH));

endmodule

// File: tb/tb_shift_taps_param.sv
// Bench for shift_taps_param: a reference model pushes expected outputs per edge to a queue,
// popped and compared after the edge; directed checks cover the documented tap values.
module tb_shift_taps_param;

  logic        clk = 1'b0;
  logic        rst, shift, recirc, clear;
  logic [7:0]  sr_in;
  logic [31:0] taps_out;
  logic [7:0]  sr_out;
  logic [3:0]  taps_valid;
  logic [6:0]  fill_count;
  logic        full;

  logic        s_shift;
  logic [11:0] s_in;
  logic [59:0] s_taps;
  logic [11:0] s_out;
  logic [4:0]  s_valid;
  logic [3:0]  s_fill;
  logic        s_full;

  always #5 clk = ~clk;

  shift_taps_param dut (
    .clk        (clk),
    .rst        (rst),
    .shift      (shift),
    .recirc     (recirc),
    .clear      (clear),
    .sr_in      (sr_in),
    .taps_out   (taps_out),
    .sr_out     (sr_out),
    .taps_valid (taps_valid),
    .fill_count (fill_count),
    .full       (full)
  );

  shift_taps_param #(
    .WIDTH       (12),
    .TAP_SPACING (3),
    .NUM_TAPS    (5)
  ) dut_small (
    .clk        (clk),
    .rst        (rst),
    .shift      (s_shift),
    .recirc     (1'b0),
    .clear      (clear),
    .sr_in      (s_in),
    .taps_out   (s_taps),
    .sr_out     (s_out),
    .taps_valid (s_valid),
    .fill_count (s_fill),
    .full       (s_full)
  );

  typedef struct packed {
    logic [31:0] taps;
    logic [7:0]  so;
    logic [3:0]  v;
    logic [6:0]  fc;
    logic        f;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_sr[64];
  int         m_fill;
  int         passed = 0;
  int         failed = 0;
  int         total  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic rs, input logic cl, input logic sh, input logic rc,
                            input logic [7:0] din);
    exp_t       e;
    logic [7:0] last;
    if (rs || cl) begin
      for (int i = 0; i < 64; i++) m_sr[i] = 8'd0;
      m_fill = 0;
    end else if (sh) begin
      last = m_sr[63];
      for (int i = 63; i > 0; i--) m_sr[i] = m_sr[i-1];
      m_sr[0] = rc ? last : din;
      if (!rc && m_fill < 64) m_fill++;
    end
    for (int k = 0; k < 4; k++) begin
      e.taps[k*8 +: 8] = m_sr[(k+1)*16-1];
      e.v[k]           = (m_fill >= (k+1)*16);
    end
    e.so = m_sr[63];
    e.fc = 7'(m_fill);
    e.f  = (m_fill == 64);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic rs, input logic cl, input logic sh, input logic rc,
                      input logic [7:0] din, input logic ssh = 1'b0,
                      input logic [11:0] sdin = 12'd0);
    exp_t e;
    rst = rs; clear = cl; shift = sh; recirc = rc; sr_in = din;
    s_shift = ssh; s_in = sdin;
    model_step(rs, cl, sh, rc, din);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk("taps_out", 64'(taps_out), 64'(e.taps));
      chk("sr_out", 64'(sr_out), 64'(e.so));
      chk("taps_valid", 64'(taps_valid), 64'(e.v));
      chk("fill_count", 64'(fill_count), 64'(e.fc));
      chk("full", 64'(full), 64'(e.f));
    end
  endtask

  initial begin
    int n;
    logic [31:0] pre_rot;
    rst = 1'b1; clear = 1'b0; shift = 1'b0; recirc = 1'b0; sr_in = '0;
    s_shift = 1'b0; s_in = '0;
    pre_rot = {8'd1, 8'd17, 8'd33, 8'd49};

    // Reset, then a stream, then clear with shift asserted
    step(1, 0, 0, 0, 8'd0);
    step(1, 0, 1, 0, 8'd7);
    chk("rst_taps", 64'(taps_out), 64'd0);
    chk("rst_fill", 64'(fill_count), 64'd0);
    chk("rst_valid", 64'(taps_valid), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_small_taps", 64'(s_taps), 64'd0);
    for (int i = 1; i <= 70; i++) step(0, 0, 1, 0, 8'(i));
    step(0, 1, 1, 0, 8'd99);
    chk("clear_taps", 64'(taps_out), 64'd0);
    chk("clear_fill", 64'(fill_count), 64'd0);
    chk("clear_valid", 64'(taps_valid), 64'd0);

    // Fill 1..64 with tap-valid staircase
    for (int i = 1; i <= 64; i++) begin
      step(0, 0, 1, 0, 8'(i));
      if (i == 16) chk("valid_at16", 64'(taps_valid), 64'h1);
      if (i == 32) chk("valid_at32", 64'(taps_valid), 64'h3);
      if (i == 48) chk("valid_at48", 64'(taps_valid), 64'h7);
    end
    chk("fill_taps", 64'(taps_out), 64'(pre_rot));
    chk("fill_sr_out", 64'(sr_out), 64'd1);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_count64", 64'(fill_count), 64'd64);
    chk("fill_valid", 64'(taps_valid), 64'hF);

    // Saturation
    step(0, 0, 1, 0, 8'd65);
    step(0, 0, 1, 0, 8'd66);
    chk("sat_sr_out", 64'(sr_out), 64'd3);
    chk("sat_tap0", 64'(taps_out[7:0]), 64'd51);
    chk("sat_fill", 64'(fill_count), 64'd64);

    // Gaps: every third cycle idle, 20 accepted shifts
    step(1, 0, 0, 0, 8'd0);
    n = 0;
    for (int c = 1; n < 20; c++) begin
      if (c % 3 == 0) begin
        step(0, 0, 0, 1, 8'hEE);
      end else begin
        n++;
        step(0, 0, 1, 0, 8'(n));
      end
    end
    chk("gap_tap0", 64'(taps_out[7:0]), 64'd5);
    chk("gap_fill", 64'(fill_count), 64'd20);

    // Recirculate after a full fill
    step(0, 1, 0, 0, 8'd0);
    for (int i = 1; i <= 64; i++) step(0, 0, 1, 0, 8'(i));
    step(0, 0, 1, 1, 8'hFF);
    chk("rot1_sr_out", 64'(sr_out), 64'd2);
    chk("rot1_tap0", 64'(taps_out[7:0]), 64'd50);
    for (int i = 2; i <= 64; i++) begin
      step(0, 0, 1, 1, 8'hFF);
      chk("rot_fill", 64'(fill_count), 64'd64);
    end
    chk("rot64_taps", 64'(taps_out), 64'(pre_rot));
    chk("rot64_sr_out", 64'(sr_out), 64'd1);

    // Parameter sweep instance: 12-bit, spacing 3, 5 taps
    step(0, 1, 0, 0, 8'd0);
    for (int i = 1; i <= 15; i++) step(0, 0, 0, 0, 8'd0, 1'b1, 12'(i));
    chk("sweep_taps", 64'(s_taps), 64'({12'd1, 12'd4, 12'd7, 12'd10, 12'd13}));
    chk("sweep_sr_out", 64'(s_out), 64'd1);
    chk("sweep_full", 64'(s_full), 64'd1);
    chk("sweep_fill", 64'(s_fill), 64'd15);
    chk("sweep_valid", 64'(s_valid), 64'h1F);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
